// File: rtl/efb_wb_pkg.sv
// Shared definitions for the EFB Wishbone master: FSM state encoding and
// the EFB SPI register map.
package efb_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  localparam logic [7:0] SPICR0   = 8'h54;
  localparam logic [7:0] SPICR1   = 8'h55;
  localparam logic [7:0] SPICR2   = 8'h56;
  localparam logic [7:0] SPIBR    = 8'h57;
  localparam logic [7:0] SPICSR   = 8'h58;
  localparam logic [7:0] SPITXDR  = 8'h59;
  localparam logic [7:0] SPISR    = 8'h5A;
  localparam logic [7:0] SPIRXDR  = 8'h5B;
  localparam logic [7:0] SPIIRQ   = 8'h5C;
  localparam logic [7:0] SPIIRQEN = 8'h5D;

endpackage

// File: rtl/efb_wb_timeout.sv
// Bus-cycle watchdog: counts BUS cycles without ack and flags the last one
// before the master must abort.
module efb_wb_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam logic [7:0] TERMINAL = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Held at zero outside BUS so every transaction starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (!run) begin
      count <= 8'd0;
    end else if (!ack) begin
      count <= count + 8'd1;
    end
  end

  // An ack in the terminal cycle wins over the abort.
  assign expired = run & ~ack & (count == TERMINAL);

endmodule

// File: rtl/efb_wb_master.sv
// Single-transaction Wishbone master for the EFB register file.
// Optional bus timeout is built when EFB_WB_TIMEOUT_EN is defined.
module efb_wb_master
  import efb_wb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WE,
  input  logic [7:0] REQ_ADR,
  input  logic [7:0] REQ_DAT,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DAT,
  output logic       RSP_ERR,
  output logic       WB_CYC_O,
  output logic       WB_STB_O,
  output logic       WB_WE_O,
  output logic [7:0] WB_ADR_O,
  output logic [7:0] WB_DAT_O,
  input  logic [7:0] WB_DAT_I,
  input  logic       WB_ACK_I,
  output logic [1:0] dbg_state
);

  // Handshake: a request transfers on a rising edge where REQ_VALID and
  // REQ_READY are both 1; REQ_READY is only offered in IDLE.
  wb_state_e  state, next_state;
  logic       live;
  logic       in_bus;
  logic       timeout_hit;
  logic       handshake;
  logic       we_q;
  logic [7:0] adr_q;
  logic [7:0] dat_q;
  logic [7:0] rdat_q;
  logic       err_q;

`ifdef EFB_WB_TIMEOUT_EN
  efb_wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst_n   (RST_N),
    .run     (in_bus),
    .ack     (WB_ACK_I),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Keeps REQ_READY low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    REQ_READY  = 1'b0;
    in_bus     = 1'b0;
    RSP_VALID  = 1'b0;
    case (state)
      ST_IDLE: begin
        REQ_READY = live;
        if (REQ_VALID && live) next_state = ST_BUS;
      end
      ST_BUS: begin
        in_bus = 1'b1;
        if (WB_ACK_I || timeout_hit) next_state = ST_DONE;
      end
      ST_DONE: begin
        RSP_VALID  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign handshake = REQ_READY & REQ_VALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      we_q   <= 1'b0;
      adr_q  <= 8'd0;
      dat_q  <= 8'd0;
      rdat_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) begin
        we_q  <= REQ_WE;
        adr_q <= REQ_ADR;
        dat_q <= REQ_DAT;
      end
      if (in_bus && (WB_ACK_I || timeout_hit)) begin
        rdat_q <= (WB_ACK_I && !we_q) ? WB_DAT_I : 8'd0;
        err_q  <= ~WB_ACK_I;
      end
    end
  end

  // Bus qualifiers decode straight from state so reset drops them with no edge.
  assign WB_CYC_O  = in_bus;
  assign WB_STB_O  = in_bus;
  assign WB_WE_O   = in_bus & we_q;
  assign WB_ADR_O  = in_bus ? adr_q : 8'd0;
  assign WB_DAT_O  = in_bus ? dat_q : 8'd0;
  assign RSP_DAT   = RSP_VALID ? rdat_q : 8'd0;
`ifdef EFB_WB_TIMEOUT_EN
  assign RSP_ERR   = RSP_VALID & err_q;
`else
  assign RSP_ERR   = 1'b0;
`endif
  assign dbg_state = state;

endmodule

// File: tb/tb_efb_wb_master.sv
// Directed bench for efb_wb_master with TIMEOUT=16; the timeout cases follow
// the EFB_WB_TIMEOUT_EN build setting.
module tb_efb_wb_master;
  import efb_wb_pkg::*;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_WE = 1'b0;
  logic [7:0] REQ_ADR = 8'd0;
  logic [7:0] REQ_DAT = 8'd0;
  logic       RSP_VALID;
  logic [7:0] RSP_DAT;
  logic       RSP_ERR;
  logic       WB_CYC_O, WB_STB_O, WB_WE_O;
  logic [7:0] WB_ADR_O, WB_DAT_O;
  logic [7:0] WB_DAT_I = 8'd0;
  logic       WB_ACK_I = 1'b0;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  efb_wb_master #(.TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADR   (REQ_ADR),
    .REQ_DAT   (REQ_DAT),
    .RSP_VALID (RSP_VALID),
    .RSP_DAT   (RSP_DAT),
    .RSP_ERR   (RSP_ERR),
    .WB_CYC_O  (WB_CYC_O),
    .WB_STB_O  (WB_STB_O),
    .WB_WE_O   (WB_WE_O),
    .WB_ADR_O  (WB_ADR_O),
    .WB_DAT_O  (WB_DAT_O),
    .WB_DAT_I  (WB_DAT_I),
    .WB_ACK_I  (WB_ACK_I),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_cyc"}, WB_CYC_O, 0);
    check({tag, "_stb"}, WB_STB_O, 0);
    check({tag, "_we"},  WB_WE_O,  0);
    check({tag, "_adr"}, WB_ADR_O, 0);
    check({tag, "_dat"}, WB_DAT_O, 0);
  endtask

  // driver: one request, ack placed on STB cycle ack_at (0 = never)
  task automatic run_txn(input string tag, input logic we, input logic [7:0] adr,
                         input logic [7:0] dat, input int ack_at, input logic [7:0] rdata,
                         input logic exp_err, input int exp_stb);
    int stb_cnt;
    logic [8:0] exp;
    exp_q.push_back({exp_err, (we || exp_err) ? 8'h00 : rdata});
    check({tag, "_ready"}, REQ_READY, 1);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADR = adr; REQ_DAT = dat;
    @(negedge CLK);
    REQ_VALID = 1'b0; REQ_WE = ~we; REQ_ADR = ~adr; REQ_DAT = ~dat;
    stb_cnt = 0;
    while (WB_STB_O && stb_cnt < 300) begin
      stb_cnt++;
      check({tag, "_cyc"}, WB_CYC_O, 1);
      check({tag, "_we"}, WB_WE_O, we);
      check({tag, "_adr"}, WB_ADR_O, adr);
      check({tag, "_wdat"}, WB_DAT_O, dat);
      check({tag, "_rspv_bus"}, RSP_VALID, 0);
      if (stb_cnt == ack_at) begin
        WB_ACK_I = 1'b1; WB_DAT_I = rdata;
      end else begin
        WB_ACK_I = 1'b0; WB_DAT_I = 8'h5C ^ stb_cnt[7:0];
      end
      @(negedge CLK);
    end
    WB_ACK_I = 1'b0;
    check({tag, "_stb_len"}, stb_cnt, exp_stb);
    check({tag, "_rspv"}, RSP_VALID, 1);
    check_idle_bus({tag, "_done"});
    exp = exp_q.pop_front();
    check({tag, "_rsp"}, {RSP_ERR, RSP_DAT}, exp);
    @(negedge CLK);
    check({tag, "_rspv_off"}, RSP_VALID, 0);
    check({tag, "_ready_back"}, REQ_READY, 1);
  endtask

  initial begin
    int n_stb, n_rsp, low_run;
    logic prev_stb;

    // reset state
    #1;
    check("rst_ready", REQ_READY, 0);
    check("rst_rspv", RSP_VALID, 0);
    check("rst_rsp", {RSP_ERR, RSP_DAT}, 0);
    check_idle_bus("rst");
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    #1 check("rel_ready_pre", REQ_READY, 0);
    @(negedge CLK);
    check("rel_ready", REQ_READY, 1);

    // write SPITXDR, ack on second STB cycle
    run_txn("wr_txdr", 1'b1, SPITXDR, 8'hA5, 2, 8'h00, 1'b0, 2);
    // read SPISR, ack on first STB cycle
    run_txn("rd_sr", 1'b0, SPISR, 8'h00, 1, 8'h18, 1'b0, 1);
    run_txn("rd_rxdr", 1'b0, SPIRXDR, 8'h33, 3, 8'h7E, 1'b0, 3);
    run_txn("wr_cr0", 1'b1, SPICR0, 8'hC4, 1, 8'hEE, 1'b0, 1);

`ifdef EFB_WB_TIMEOUT_EN
    run_txn("to_abort", 1'b0, SPISR, 8'h00, 0, 8'h99, 1'b1, TO);
    run_txn("to_ack_wins", 1'b0, SPISR, 8'h00, TO, 8'hC3, 1'b0, TO);
`else
    run_txn("no_to_wait", 1'b0, SPISR, 8'h00, 40, 8'hC3, 1'b0, 40);
`endif

    // ack while idle must be ignored
    WB_ACK_I = 1'b1; WB_DAT_I = 8'hFF;
    @(negedge CLK);
    check("stray_ack_rspv", RSP_VALID, 0);
    check("stray_ack_state", dbg_state, ST_IDLE);
    check_idle_bus("stray_ack");
    WB_ACK_I = 1'b0;

    // REQ_VALID held for three back-to-back writes
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADR = SPICR1; REQ_DAT = 8'h3C;
    n_stb = 0; n_rsp = 0; low_run = 0; prev_stb = 1'b0;
    for (int cyc = 0; cyc < 40 && n_rsp < 3; cyc++) begin
      @(negedge CLK);
      if (WB_STB_O && !prev_stb) begin
        n_stb++;
        if (n_stb > 1) check("b2b_gap", low_run >= 2, 1);
      end
      low_run = WB_STB_O ? 0 : low_run + 1;
      if (RSP_VALID) begin
        n_rsp++;
        check("b2b_rsp", {RSP_ERR, RSP_DAT}, 0);
        if (n_rsp == 3) REQ_VALID = 1'b0;
      end
      WB_ACK_I = WB_STB_O;
      prev_stb = WB_STB_O;
    end
    WB_ACK_I = 1'b0;
    check("b2b_stb_count", n_stb, 3);
    check("b2b_rsp_count", n_rsp, 3);
    @(negedge CLK);
    check("b2b_ready", REQ_READY, 1);

    // reset on second STB cycle of a read
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADR = SPIRXDR;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("mid_stb1", WB_STB_O, 1);
    @(negedge CLK);
    check("mid_stb2", WB_STB_O, 1);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_cyc", WB_CYC_O, 0);
    check("mid_rst_stb", WB_STB_O, 0);
    check("mid_rst_ready", REQ_READY, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      check("mid_rst_rspv", RSP_VALID, 0);
    end
    RST_N = 1'b1;
    #1 check("mid_rel_ready_pre", REQ_READY, 0);
    @(negedge CLK);
    check("mid_rel_ready", REQ_READY, 1);
    check("mid_rel_rspv", RSP_VALID, 0);

    run_txn("post_rst_rd", 1'b0, SPIIRQ, 8'h00, 2, 8'h81, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/efb_wb_master.md
EFB_WB_MASTER -- requirements
Module: efb_wb_master

Interface
REQ-001 Parameter TIMEOUT, default 64, gives the cycles WB_STB_O may stay high without WB_ACK_I before abort; legal range 2..255.
REQ-002 CLK  in  1  system clock, on-chip oscillator domain.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 REQ_VALID  in  1  controller requests one bus transaction.
REQ-005 REQ_READY  out  1  block accepts a request this cycle.
REQ-006 REQ_WE  in  1  1=write, 0=read.
REQ-007 REQ_ADR  in  8  EFB register address.
REQ-008 REQ_DAT  in  8  write data.
REQ-009 RSP_VALID  out  1  one-cycle completion pulse.
REQ-010 RSP_DAT  out  8  read data; 0 for writes and errors.
REQ-011 RSP_ERR  out  1  transaction aborted by timeout; qualified by RSP_VALID.
REQ-012 WB_CYC_O, WB_STB_O, WB_WE_O  out  1 each  Wishbone master controls.
REQ-013 WB_ADR_O, WB_DAT_O  out  8 each  Wishbone address and write data.
REQ-014 WB_DAT_I  in  8, WB_ACK_I  in  1  Wishbone slave read data and acknowledge.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUS, DONE.
REQ-016 REQ_READY SHALL be 1 only in IDLE; a handshake is REQ_VALID & REQ_READY at a rising edge.
REQ-017 On handshake, REQ_WE/ADR/DAT SHALL be registered and the FSM SHALL enter BUS; CYC and STB go high the next cycle.
REQ-018 In BUS, CYC, STB, WE, ADR and DAT SHALL be held constant until the transaction ends.
REQ-019 WB_ACK_I sampled high in BUS SHALL end the transaction: capture WB_DAT_I on reads and enter DONE.
REQ-020 CYC and STB SHALL be low in DONE; RSP_VALID SHALL be 1 for exactly that cycle, then the FSM returns to IDLE.
REQ-021 The turnaround SHALL leave at least two low cycles of STB between back-to-back transactions.
REQ-022 WB_ACK_I outside BUS SHALL be ignored.
REQ-023 The timeout counter SHALL clear on entering BUS and increment each BUS cycle without ack.
REQ-024 On reaching TIMEOUT, the FSM SHALL enter DONE with RSP_ERR=1 and RSP_DAT=0.
REQ-025 If ack and the timeout terminal count occur in the same cycle, the ack SHALL win and RSP_ERR SHALL be 0.
REQ-026 WB_WE_O, WB_ADR_O and WB_DAT_O SHALL be 0 whenever CYC is low.

Reset
REQ-027 RST_N low SHALL immediately force IDLE and drive every output to 0, REQ_READY included; the timeout counter clears.
REQ-028 Reset mid-transaction SHALL drop CYC and STB without waiting for ack, and no RSP_VALID SHALL follow.
REQ-029 REQ_READY SHALL rise on the first CLK edge after RST_N deasserts.

Configuration
REQ-030 With EFB_WB_TIMEOUT_EN defined, REQ-023..025 apply.
REQ-031 With EFB_WB_TIMEOUT_EN undefined, the counter SHALL not be built, BUS SHALL wait indefinitely for ack, and RSP_ERR SHALL be tied to 0.

Structure
REQ-032 The shared package efb_wb_pkg SHALL hold the state encoding and the EFB SPI register address constants: SPICR0 0x54, SPICR1 0x55, SPICR2 0x56, SPIBR 0x57, SPICSR 0x58, SPITXDR 0x59, SPISR 0x5A, SPIRXDR 0x5B, SPIIRQ 0x5C, SPIIRQEN 0x5D.
REQ-033 The timeout counter SHALL be the sub-module efb_wb_timeout, instantiated only under EFB_WB_TIMEOUT_EN.

Verification
REQ-034 Write 0x59/0xA5, ack 2 cycles after STB -> STB/CYC/WE high 2 cycles, ADR 0x59, DAT 0xA5; RSP_VALID 1 cycle, ERR 0, RSP_DAT 0.
REQ-035 Read 0x5A, WB_DAT_I 0x18 with ack on first STB cycle -> RSP_DAT 0x18, ERR 0, WE low throughout.
REQ-036 TIMEOUT=16, macro on, no ack -> STB high exactly 16 cycles, then RSP_VALID with ERR 1, RSP_DAT 0x00.
REQ-037 TIMEOUT=16, ack on the 16th STB cycle -> ERR 0, read data captured.
REQ-038 REQ_VALID held high for 3 writes -> 3 transactions, each STB gap at least 2 cycles, 3 RSP_VALID pulses.
REQ-039 RST_N low on the 2nd STB cycle -> CYC/STB low with no clock edge, no RSP_VALID, REQ_READY 1 on the first edge after release.
